// File: rtl/core_pkg.sv
// Types shared by the ARM core's hazard logic: the shadow-pipeline entry
// and the priority classes of the hazard controller's strobe encoder.
package core_pkg;

  localparam int CORE_DEST_W = 4;

  typedef struct packed {
    logic                   valid;
    logic [CORE_DEST_W-1:0] dest;
    logic                   wb_en;
    logic                   mem_r_en;
  } hazard_entry_t;

  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_BRANCH   = 2'd2,
    HZ_STALL    = 2'd3
  } hz_prio_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Two-entry shadow of the destinations held in EXE and MEM. It advances with
// the real pipeline and takes an invalid entry whenever ID/EX receives a bubble.
module hazard_shadow_pipe
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          load,
  input  hazard_entry_t id_entry,
  output hazard_entry_t s_exe,
  output hazard_entry_t s_mem
);

  hazard_entry_t exe_reg;
  hazard_entry_t mem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_reg <= '0;
      mem_reg <= '0;
    end else if (advance) begin
      mem_reg <= exe_reg;
      exe_reg <= load ? id_entry : '0;
    end
  end

  assign s_exe = exe_reg;
  assign s_mem = mem_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: RAW / load-use detection against
// the EXE/MEM shadow, prioritised freeze/flush strobes and a saturating stall counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int DEST_W = CORE_DEST_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic              id_valid,
  input  logic [DEST_W-1:0] id_src_1,
  input  logic [DEST_W-1:0] id_src_2,
  input  logic              id_two_src,
  input  logic [DEST_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              exe_branch_taken,
  input  logic              mem_ready,
  output logic              pc_freeze,
  output logic              if_id_freeze,
  output logic              if_id_flush,
  output logic              id_ex_freeze,
  output logic              id_ex_flush,
  output logic [CNT_W-1:0]  stall_count
);

  hazard_entry_t    id_entry;
  hazard_entry_t    s_exe;
  hazard_entry_t    s_mem;
  hazard_entry_t    shadow [2];
  logic [1:0]       match;
  logic             hazard;
  logic             shadow_load;
  hz_prio_t         prio;
  logic [CNT_W-1:0] stall_count_reg;

  assign id_entry = '{valid: id_valid, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};

  // The ID/EX register only takes a real instruction when nothing overrides it.
  assign shadow_load = id_valid & (prio == HZ_NONE);

  hazard_shadow_pipe u_shadow (
    .clk      (clk),
    .rst      (rst),
    .advance  (mem_ready),
    .load     (shadow_load),
    .id_entry (id_entry),
    .s_exe    (s_exe),
    .s_mem    (s_mem)
  );

  assign shadow[0] = s_exe;
  assign shadow[1] = s_mem;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_match
      assign match[gi] = id_valid & shadow[gi].valid & shadow[gi].wb_en &
                         ((id_src_1 == shadow[gi].dest) |
                          (id_two_src & (id_src_2 == shadow[gi].dest)));
    end
  endgenerate

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard = forward_en ? (match[0] & s_exe.mem_r_en) : (|match);

  always_comb begin
    prio = HZ_NONE;
    if (!mem_ready) begin
      prio = HZ_MEM_WAIT;
    end else if (exe_branch_taken) begin
      prio = HZ_BRANCH;
    end else if (hazard) begin
      prio = HZ_STALL;
    end
  end

  always_comb begin
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_freeze = 1'b0;
    id_ex_flush  = 1'b0;
    case (prio)
      HZ_MEM_WAIT: begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_freeze = 1'b1;
      end
      HZ_BRANCH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      HZ_STALL: begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_flush  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if ((prio == HZ_STALL) && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_reg;

  a_wait_no_flush: assert property (@(posedge clk) disable iff (rst)
    (prio == HZ_MEM_WAIT) |-> !(if_id_flush || id_ex_flush));
  a_idex_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(id_ex_freeze && id_ex_flush));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against an in-flight instruction list model; a CNT_W=2 copy covers saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en;
  logic       id_valid;
  logic [3:0] id_src_1;
  logic [3:0] id_src_2;
  logic       id_two_src;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       exe_branch_taken;
  logic       mem_ready;

  logic        pc_freeze_a, if_id_freeze_a, if_id_flush_a, id_ex_freeze_a, id_ex_flush_a;
  logic        pc_freeze_b, if_id_freeze_b, if_id_flush_b, id_ex_freeze_b, id_ex_flush_b;
  logic [15:0] stall_count_a;
  logic [1:0]  stall_count_b;
  logic [4:0]  strb_a;
  logic [4:0]  strb_b;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src_1(id_src_1), .id_src_2(id_src_2), .id_two_src(id_two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .exe_branch_taken(exe_branch_taken), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze_a), .if_id_freeze(if_id_freeze_a), .if_id_flush(if_id_flush_a),
    .id_ex_freeze(id_ex_freeze_a), .id_ex_flush(id_ex_flush_a), .stall_count(stall_count_a)
  );

  hazard_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src_1(id_src_1), .id_src_2(id_src_2), .id_two_src(id_two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .exe_branch_taken(exe_branch_taken), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze_b), .if_id_freeze(if_id_freeze_b), .if_id_flush(if_id_flush_b),
    .id_ex_freeze(id_ex_freeze_b), .id_ex_flush(id_ex_flush_b), .stall_count(stall_count_b)
  );

  // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush}
  assign strb_a = {pc_freeze_a, if_id_freeze_a, if_id_flush_a, id_ex_freeze_a, id_ex_flush_a};
  assign strb_b = {pc_freeze_b, if_id_freeze_b, if_id_flush_b, id_ex_freeze_b, id_ex_flush_b};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: instructions past ID, youngest first (index 0 = EXE, 1 = MEM).
  typedef struct {
    bit       valid;
    bit [3:0] dest;
    bit       wb;
    bit       ld;
  } instr_t;

  instr_t      inflight[$];
  int unsigned m_count_a;
  int unsigned m_count_b;

  function automatic void model_reset();
    instr_t bub;
    bub = '{valid: 1'b0, dest: 4'd0, wb: 1'b0, ld: 1'b0};
    inflight.delete();
    inflight.push_back(bub);
    inflight.push_back(bub);
    m_count_a = 0;
    m_count_b = 0;
  endfunction

  function automatic bit reads(instr_t p);
    return p.valid && p.wb && ((id_src_1 == p.dest) || (id_two_src && (id_src_2 == p.dest)));
  endfunction

  function automatic bit model_hazard();
    if (!id_valid) return 1'b0;
    if (forward_en) return reads(inflight[0]) && inflight[0].ld;
    return reads(inflight[0]) || reads(inflight[1]);
  endfunction

  function automatic logic [4:0] model_strobes();
    if (!mem_ready) return 5'b11010;
    if (exe_branch_taken) return 5'b00101;
    if (model_hazard()) return 5'b11001;
    return 5'b00000;
  endfunction

  task automatic tick();
    instr_t enter;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (mem_ready) begin
      enter = '{valid: 1'b0, dest: 4'd0, wb: 1'b0, ld: 1'b0};
      if (!exe_branch_taken && model_hazard()) begin
        if (m_count_a < 65535) m_count_a++;
        if (m_count_b < 3) m_count_b++;
      end else if (id_valid && !exe_branch_taken) begin
        enter = '{valid: 1'b1, dest: id_dest, wb: id_wb_en, ld: id_mem_r_en};
      end
      inflight.push_front(enter);
      void'(inflight.pop_back());
    end
    #1;
  endtask

  task automatic set_id(input bit v, input bit [3:0] s1, input bit [3:0] s2, input bit two,
                        input bit [3:0] d, input bit wb, input bit ld);
    id_valid    = v;
    id_src_1    = s1;
    id_src_2    = s2;
    id_two_src  = two;
    id_dest     = d;
    id_wb_en    = wb;
    id_mem_r_en = ld;
  endtask

  task automatic do_reset(input bit fwd);
    forward_en       = fwd;
    rst              = 1'b1;
    exe_branch_taken = 1'b0;
    mem_ready        = 1'b1;
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000) begin
      n_fail++; $display("FAIL reset_strobes got=%b required=%b", strb_a, 5'b00000);
    end
    n_checks++;
    if (stall_count_a !== 16'd0 || stall_count_b !== 2'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d/%0d required=0/0", stall_count_a, stall_count_b);
    end
    $display("reset: strobes=%b count=%0d", strb_a, stall_count_a);
    tick();
  endtask

  task automatic test_load_use();
    do_reset(1'b1);
    set_id(1'b1, 4'd5, 4'd6, 1'b1, 4'd1, 1'b1, 1'b1);   // LDR R1
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000) begin
      n_fail++; $display("FAIL load_use_ldr got=%b required=%b", strb_a, 5'b00000);
    end
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);   // ADD R2,R1,R3
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b11001) begin
      n_fail++; $display("FAIL load_use_stall got=%b required=%b", strb_a, 5'b11001);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000 || stall_count_a !== 16'd1) begin
      n_fail++; $display("FAIL load_use_release got=%b cnt=%0d required=00000 cnt=1", strb_a, stall_count_a);
    end
    $display("load_use: strobes=%b count=%0d", strb_a, stall_count_a);
    tick();
  endtask

  task automatic test_no_forward();
    logic [4:0] req [4];
    int unsigned req_cnt [4];
    do_reset(1'b0);
    set_id(1'b1, 4'd7, 4'd8, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD R4
    tick();
    set_id(1'b1, 4'd4, 4'd6, 1'b1, 4'd5, 1'b1, 1'b0);   // SUB R5,R4,R6
    req = '{5'b11001, 5'b11001, 5'b00000, 5'b00000};
    req_cnt = '{0, 1, 2, 2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (strb_a !== req[i] || stall_count_a !== 16'(req_cnt[i])) begin
        n_fail++;
        $display("FAIL nofwd_adjacent[%0d] got=%b cnt=%0d required=%b cnt=%0d",
                 i, strb_a, stall_count_a, req[i], req_cnt[i]);
      end
      tick();
    end
    set_id(1'b1, 4'd7, 4'd8, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD R4
    tick();
    set_id(1'b1, 4'd10, 4'd11, 1'b1, 4'd9, 1'b1, 1'b0); // independent
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000) begin
      n_fail++; $display("FAIL nofwd_indep got=%b required=00000", strb_a);
    end
    tick();
    set_id(1'b1, 4'd4, 4'd6, 1'b1, 4'd5, 1'b1, 1'b0);   // SUB R5,R4,R6
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b11001) begin
      n_fail++; $display("FAIL nofwd_gap_stall got=%b required=11001", strb_a);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000 || stall_count_a !== 16'd3) begin
      n_fail++; $display("FAIL nofwd_gap_release got=%b cnt=%0d required=00000 cnt=3", strb_a, stall_count_a);
    end
    $display("no_forward: strobes=%b count=%0d", strb_a, stall_count_a);
    tick();
  endtask

  task automatic test_single_src();
    do_reset(1'b0);
    set_id(1'b1, 4'd7, 4'd8, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD R4
    tick();
    set_id(1'b1, 4'd7, 4'd4, 1'b0, 4'd5, 1'b1, 1'b0);   // src_2=R4 but unused
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000) begin
      n_fail++; $display("FAIL single_src got=%b required=00000", strb_a);
    end
    $display("single_src: strobes=%b", strb_a);
    tick();
  endtask

  task automatic test_branch_vs_hazard();
    do_reset(1'b1);
    set_id(1'b1, 4'd5, 4'd6, 1'b1, 4'd1, 1'b1, 1'b1);   // LDR R1
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);   // ADD R2,R1,R3
    exe_branch_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00101 || stall_count_a !== 16'd0) begin
      n_fail++; $display("FAIL branch_flush got=%b cnt=%0d required=00101 cnt=0", strb_a, stall_count_a);
    end
    tick();
    exe_branch_taken = 1'b0;
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000 || stall_count_a !== 16'd0) begin
      n_fail++; $display("FAIL branch_after got=%b cnt=%0d required=00000 cnt=0", strb_a, stall_count_a);
    end
    $display("branch: strobes=%b count=%0d", strb_a, stall_count_a);
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset(1'b1);
    set_id(1'b1, 4'd5, 4'd6, 1'b1, 4'd1, 1'b1, 1'b1);   // LDR R1
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);   // ADD R2,R1,R3
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (strb_a !== 5'b11010 || stall_count_a !== 16'd0) begin
        n_fail++; $display("FAIL mem_wait[%0d] got=%b cnt=%0d required=11010 cnt=0", i, strb_a, stall_count_a);
      end
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b11001 || stall_count_a !== 16'd0) begin
      n_fail++; $display("FAIL mem_wait_resume got=%b cnt=%0d required=11001 cnt=0", strb_a, stall_count_a);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (strb_a !== 5'b00000 || stall_count_a !== 16'd1) begin
      n_fail++; $display("FAIL mem_wait_release got=%b cnt=%0d required=00000 cnt=1", strb_a, stall_count_a);
    end
    $display("mem_wait: strobes=%b count=%0d", strb_a, stall_count_a);
    tick();
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    for (int r = 0; r < 3; r++) begin
      set_id(1'b1, 4'd7, 4'd8, 1'b1, 4'd4, 1'b1, 1'b0); // ADD R4
      tick();
      set_id(1'b1, 4'd4, 4'd6, 1'b1, 4'd5, 1'b1, 1'b0); // SUB R5,R4,R6
      tick();
      tick();
      tick();
    end
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall_count_b !== 2'd3 || stall_count_a !== 16'd6) begin
      n_fail++; $display("FAIL saturate got=%0d/%0d required=3/6", stall_count_b, stall_count_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_count_b !== 2'd0 || stall_count_a !== 16'd0 || strb_a !== 5'b00000 || strb_b !== 5'b00000) begin
      n_fail++; $display("FAIL saturate_reset got=%0d/%0d %b/%b required=0/0 00000/00000",
                         stall_count_b, stall_count_a, strb_b, strb_a);
    end
    $display("saturation: count_b=%0d count_a=%0d", stall_count_b, stall_count_a);
    tick();
  endtask

  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_random(input bit fwd, input int cycles);
    logic [4:0] exp_s;
    int errs;
    errs = 0;
    do_reset(fwd);
    for (int i = 0; i < cycles; i++) begin
      rst              = ($urandom_range(0, 63) == 0);
      id_valid         = ($urandom_range(0, 3) != 0);
      id_src_1         = pick_reg();
      id_src_2         = pick_reg();
      id_two_src       = $urandom_range(0, 1);
      id_dest          = pick_reg();
      id_wb_en         = ($urandom_range(0, 3) != 0);
      id_mem_r_en      = $urandom_range(0, 1);
      exe_branch_taken = ($urandom_range(0, 7) == 0);
      mem_ready        = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_s = model_strobes();
      n_checks++;
      if (strb_a !== exp_s || strb_b !== exp_s) begin
        n_fail++; errs++;
        $display("FAIL rand_strobes fwd=%0d cyc=%0d got=%b/%b required=%b", fwd, i, strb_a, strb_b, exp_s);
      end
      n_checks++;
      if (stall_count_a !== 16'(m_count_a) || stall_count_b !== 2'(m_count_b)) begin
        n_fail++; errs++;
        $display("FAIL rand_count fwd=%0d cyc=%0d got=%0d/%0d required=%0d/%0d",
                 fwd, i, stall_count_a, stall_count_b, m_count_a, m_count_b);
      end
      tick();
    end
    rst = 1'b0;
    $display("random fwd=%0d: %0d cycles, %0d errors, final count=%0d", fwd, cycles, errs, m_count_a);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_no_forward();
    test_single_src();
    test_branch_vs_hazard();
    test_mem_wait();
    test_saturation();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
